data_ram_arbiter: RTL and testbench

//  Shares the single-port data RAM between two requesters: master 0 (CPU MEM stage) and

---
 rtl/data_ram_arbiter_pkg.sv | 18 +
 rtl/data_ram_arbiter_rr_arbiter2.sv | 33 +++
 rtl/data_ram_arbiter.sv | 148 ++++++++++++++
 tb/tb_data_ram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_arbiter_pkg.sv
// data_ram_arbiter_pkg
//   Shared types for the data RAM arbiter: FSM state encoding and the
//   owner codes that identify which master holds the current access.
package data_ram_arbiter_pkg;

  // IDLE -> ACCESS -> RESP -> IDLE; one access every three cycles.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_ACCESS = 2'b01,
    ARB_RESP   = 2'b10
  } arb_state_e;

  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/data_ram_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Combinational winner select between two requesters.
//   Ports:
//     req_i        [1:0] request vector, bit 0 = master 0, bit 1 = master 1
//     last_grant_i       master served by the previous completed access
//     valid_o            at least one request is present
//     winner_o           selected master (ARB_M0 when nothing is requested)
//   With ROUND_ROBIN != 0 a tie goes to the master that was not served last;
//   otherwise master 0 wins every tie.
module rr_arbiter2
  import data_ram_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic [1:0] req_i,
  input  arb_owner_e last_grant_i,
  output logic       valid_o,
  output arb_owner_e winner_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = ARB_M0;
    case (req_i)
      2'b10:   winner_o = ARB_M1;
      2'b11: begin
        if ((ROUND_ROBIN != 0) && (last_grant_i == ARB_M0)) winner_o = ARB_M1;
      end
      default: winner_o = ARB_M0;
    endcase
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
//   Shares the single-port data RAM between master 0 (CPU MEM stage) and
//   master 1 (DMA/debug). Each access runs IDLE -> ACCESS -> RESP: the
//   request is latched in IDLE, the RAM is enabled for exactly the ACCESS
//   cycle, and the owner's ack pulses during RESP.
//   Ports:
//     clk, rst                 clock; asynchronous active-low reset
//     mN_req_i/we_i/addr_i/    master N command (req held until ack)
//     mN_sel_i/wdata_i
//     mN_ack_o                 one-cycle completion pulse
//     m0_stall_o               m0_req_i & ~m0_ack_o, for the pipeline stall
//     rdata_o                  read data, valid while the matching ack is high
//     ram_ce_o/we_o/addr_o/    RAM command port
//     sel_o/wdata_o
//     ram_rdata_i              RAM read data (combinational from ram_addr_o)
//     busy_o                   FSM not in IDLE
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int  ADDR_W      = 32,
  parameter int  DATA_W      = 32,
  parameter int  ROUND_ROBIN = 1,
  localparam int SEL_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic              m0_stall_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [SEL_W-1:0]  ram_sel_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  arb_owner_e        last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              arb_valid;
  arb_owner_e        arb_winner;

  rr_arbiter2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_rr_arbiter2 (
    .req_i        ({m1_req_i, m0_req_i}),
    .last_grant_i (last_grant_q),
    .valid_o      (arb_valid),
    .winner_o     (arb_winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= ARB_M0;
      last_grant_q <= ARB_M1;  // m0 wins the first tie after reset
      we_q         <= 1'b0;
      addr_q       <= '0;
      sel_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    sel_d        = sel_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (arb_valid) begin
          state_d = ARB_ACCESS;
          owner_d = arb_winner;
          if (arb_winner == ARB_M1) begin
            we_d    = m1_we_i;
            addr_d  = m1_addr_i;
            sel_d   = m1_sel_i;
            wdata_d = m1_wdata_i;
          end else begin
            we_d    = m0_we_i;
            addr_d  = m0_addr_i;
            sel_d   = m0_sel_i;
            wdata_d = m0_wdata_i;
          end
        end
      end
      ARB_ACCESS: begin
        // The RAM read path is combinational from ram_addr_o, so the word is
        // already valid here; writes leave the read register untouched.
        state_d = ARB_RESP;
        if (!we_q) rdata_d = ram_rdata_i;
      end
      ARB_RESP: begin
        // Requests are ignored here so the acked master can drop or renew.
        state_d      = ARB_IDLE;
        last_grant_d = owner_q;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Command registers hold between accesses; only ce/we gate the RAM.
  assign ram_ce_o    = (state_q == ARB_ACCESS);
  assign ram_we_o    = (state_q == ARB_ACCESS) && we_q;
  assign ram_addr_o  = addr_q;
  assign ram_sel_o   = sel_q;
  assign ram_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;

  assign m0_ack_o   = (state_q == ARB_RESP) && (owner_q == ARB_M0);
  assign m1_ack_o   = (state_q == ARB_RESP) && (owner_q == ARB_M1);
  assign m0_stall_o = m0_req_i && !m0_ack_o;
  assign busy_o     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_data_ram_arbiter.sv
module tb_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clr;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m0_stall, m1_ack, busy;
  logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;
  logic        ram_ce, ram_we;
  logic [3:0]  ram_sel;

  logic        fp_m0_req, fp_m1_req;
  logic        fp_m0_ack, fp_m0_stall, fp_m1_ack, fp_busy, fp_ram_ce, fp_ram_we;
  logic [31:0] fp_rdata, fp_ram_addr, fp_ram_wdata;
  logic [3:0]  fp_ram_sel;
  logic [31:0] fp_ram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ram_mem [64];
  logic [31:0] ref_mem [64];
  int          last_model;
  logic [31:0] rdata_model;

  always #5 clk = ~clk;

  data_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_sel_i(m0_sel),
    .m0_wdata_i(m0_wdata), .m0_ack_o(m0_ack), .m0_stall_o(m0_stall),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_sel_i(m1_sel),
    .m1_wdata_i(m1_wdata), .m1_ack_o(m1_ack),
    .rdata_o(rdata), .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_sel_o(ram_sel), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .busy_o(busy)
  );

  data_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req_i(fp_m0_req), .m0_we_i(1'b0), .m0_addr_i(32'h40), .m0_sel_i(4'hF),
    .m0_wdata_i(32'h0), .m0_ack_o(fp_m0_ack), .m0_stall_o(fp_m0_stall),
    .m1_req_i(fp_m1_req), .m1_we_i(1'b0), .m1_addr_i(32'h80), .m1_sel_i(4'hF),
    .m1_wdata_i(32'h0), .m1_ack_o(fp_m1_ack),
    .rdata_o(fp_rdata), .ram_ce_o(fp_ram_ce), .ram_we_o(fp_ram_we), .ram_addr_o(fp_ram_addr),
    .ram_sel_o(fp_ram_sel), .ram_wdata_o(fp_ram_wdata), .ram_rdata_i(fp_ram_rdata),
    .busy_o(fp_busy)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h9E37_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  // Behavioural single-port RAM attached to the round-robin instance.
  assign ram_rdata    = ram_mem[ram_addr[7:2]];
  assign fp_ram_rdata = 32'h5A5A_0F0F;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= init_word(i);
    end else if (ram_ce && ram_we) begin
      ram_mem[ram_addr[7:2]] <= merge(ram_mem[ram_addr[7:2]], ram_wdata, ram_sel);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] w);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = a; m0_sel = s; m0_wdata = w;
    end else begin
      m1_req = req; m1_we = we; m1_addr = a; m1_sel = s; m1_wdata = w;
    end
  endtask

  // Applies an acked access to the reference model and checks read data.
  task automatic retire(input string tag, input logic we, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] w);
    if (we) begin
      ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], w, s);
      chk({tag, "_rdata_hold"}, rdata, rdata_model);
    end else begin
      rdata_model = ref_mem[a[7:2]];
      chk({tag, "_rdata"}, rdata, rdata_model);
    end
  endtask

  // Single-master access; called at a negedge with the arbiter idle.
  task automatic do_access(input int m, input logic we, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] w, input string tag);
    drive(m, 1'b1, we, a, s, w);
    @(posedge clk); @(negedge clk);
    chk({tag, "_acc_ce"}, ram_ce, 1'b1);
    chk({tag, "_acc_we"}, ram_we, we);
    chk({tag, "_acc_addr"}, ram_addr, a);
    chk({tag, "_acc_sel"}, ram_sel, s);
    if (we) chk({tag, "_acc_wdata"}, ram_wdata, w);
    chk({tag, "_acc_acks"}, {m1_ack, m0_ack}, 2'b00);
    chk({tag, "_acc_busy"}, busy, 1'b1);
    chk({tag, "_acc_stall"}, m0_stall, (m == 0));
    @(posedge clk); @(negedge clk);
    chk({tag, "_rsp_acks"}, {m1_ack, m0_ack}, (m == 0) ? 2'b01 : 2'b10);
    chk({tag, "_rsp_ce_we"}, {ram_ce, ram_we}, 2'b00);
    chk({tag, "_rsp_stall"}, m0_stall, 1'b0);
    retire(tag, we, a, s, w);
    last_model = m;
    drive(m, 1'b0, 1'b0, a, s, w);
    @(posedge clk); @(negedge clk);
    chk({tag, "_idle"}, {busy, m1_ack, m0_ack}, 3'b000);
  endtask

  // Both masters request in the same cycle; the model predicts service order.
  task automatic do_pair(input logic [1:0] we, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [3:0] s0, input logic [3:0] s1, input logic [31:0] w0,
                         input logic [31:0] w1, input string tag);
    logic [31:0] a [2];
    logic [3:0]  s [2];
    logic [31:0] w [2];
    int first, want, cyc;
    bit got;
    a[0] = a0; a[1] = a1; s[0] = s0; s[1] = s1; w[0] = w0; w[1] = w1;
    first = (last_model == 1) ? 0 : 1;
    drive(0, 1'b1, we[0], a0, s0, w0);
    drive(1, 1'b1, we[1], a1, s1, w1);
    for (int k = 0; k < 2; k++) begin
      want = (k == 0) ? first : 1 - first;
      cyc = 0;
      got = 0;
      while (!got && cyc < 6) begin
        @(posedge clk); @(negedge clk);
        cyc++;
        if (m0_ack || m1_ack) got = 1;
      end
      chk($sformatf("%s_k%0d_ack_seen", tag, k), got, 1'b1);
      if (got) begin
        chk($sformatf("%s_k%0d_latency", tag, k), cyc, (k == 0) ? 2 : 3);
        chk($sformatf("%s_k%0d_who", tag, k), {m1_ack, m0_ack}, (want == 0) ? 2'b01 : 2'b10);
        chk($sformatf("%s_k%0d_addr", tag, k), ram_addr, a[want]);
        if (we[want]) chk($sformatf("%s_k%0d_wdata", tag, k), ram_wdata, w[want]);
        retire($sformatf("%s_k%0d", tag, k), we[want], a[want], s[want], w[want]);
        last_model = want;
      end
      drive(want, 1'b0, 1'b0, a[want], s[want], w[want]);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int          kind, cyc;
    bit          got;
    logic [31:0] ra0, ra1, rw0, rw1;
    logic [3:0]  rs0, rs1;
    logic [1:0]  rwe;

    rst = 1'b0;
    mem_clr = 1'b1;
    fp_m0_req = 1'b0;
    fp_m1_req = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    last_model = 1;
    rdata_model = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_acks", {m1_ack, m0_ack}, 2'b00);
    chk("rst_ce_we", {ram_ce, ram_we}, 2'b00);
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_sel", ram_sel, 4'h0);
    chk("rst_wdata", ram_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stall", m0_stall, 1'b0);
    mem_clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Directed write, read-back, and byte-lane merge.
    do_access(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, "t1_wr");
    do_access(0, 1'b0, 32'h10, 4'b1111, 32'h0, "t2_rd");
    chk("t2_literal", rdata, 32'hDEADBEEF);
    do_access(0, 1'b1, 32'h20, 4'b1111, 32'h11223344, "t5_init");
    do_access(1, 1'b1, 32'h20, 4'b0010, 32'h0000AB00, "t5_byte");
    do_access(1, 1'b0, 32'h20, 4'b1111, 32'h0, "t5_rd");
    chk("t5_literal", rdata, 32'h1122AB44);

    // Round-robin ties: the master not served last goes first.
    do_pair(2'b00, 32'h10, 32'h20, 4'hF, 4'hF, 32'h0, 32'h0, "t3_pairA");
    do_access(0, 1'b0, 32'h24, 4'hF, 32'h0, "t3_single");
    do_pair(2'b11, 32'h28, 32'h2C, 4'hF, 4'hF, 32'h01020304, 32'hA0B0C0D0, "t3_pairB");

    // Fixed priority: m0 holds its request, m1 waits until it drops.
    fp_m0_req = 1'b1;
    fp_m1_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("t4_m1ack_c%0d", c), fp_m1_ack, 1'b0);
      chk($sformatf("t4_m0ack_c%0d", c), fp_m0_ack, (c % 3 == 2));
      chk($sformatf("t4_ce_c%0d", c), fp_ram_ce, (c % 3 == 1));
      chk($sformatf("t4_busy_c%0d", c), fp_busy, (c % 3 != 0));
      chk($sformatf("t4_stall_c%0d", c), fp_m0_stall, (c % 3 != 2));
      chk($sformatf("t4_addr_c%0d", c), fp_ram_addr, 32'h40);
    end
    chk("t4_rdata", fp_rdata, 32'h5A5A_0F0F);
    chk("t4_we_sel_wd", {fp_ram_we, fp_ram_sel, fp_ram_wdata}, {1'b0, 4'hF, 32'h0});
    fp_m0_req = 1'b0;
    cyc = 0;
    got = 0;
    while (!got && cyc < 6) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (fp_m1_ack) got = 1;
    end
    chk("t4_m1_served", got, 1'b1);
    chk("t4_m1_latency", cyc, 2);
    fp_m1_req = 1'b0;
    @(posedge clk); @(negedge clk);

    // Reset in the middle of a write access.
    drive(0, 1'b1, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D);
    @(posedge clk); @(negedge clk);
    chk("t6_ce_before", {ram_ce, ram_we}, 2'b11);
    #2 rst = 1'b0;
    #1;
    chk("t6_ce_we_drop", {ram_ce, ram_we}, 2'b00);
    chk("t6_busy_drop", busy, 1'b0);
    chk("t6_rdata_clr", rdata, 32'h0);
    chk("t6_addr_clr", ram_addr, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("t6_no_ack_%0d", c), {m1_ack, m0_ack, busy}, 3'b000);
    end
    rst = 1'b1;
    last_model = 1;
    rdata_model = 32'h0;
    @(negedge clk);
    do_pair(2'b10, 32'h30, 32'h34, 4'hF, 4'h3, 32'h0, 32'h7777_8888, "t6_after");

    // Randomized mix of single and paired accesses.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      ra0 = $urandom_range(0, 255);
      ra1 = $urandom_range(0, 255);
      rs0 = 4'($urandom_range(1, 15));
      rs1 = 4'($urandom_range(1, 15));
      rw0 = $urandom;
      rw1 = $urandom;
      rwe = 2'($urandom_range(0, 3));
      if (kind == 2)
        do_pair(rwe, ra0, ra1, rs0, rs1, rw0, rw1, $sformatf("rnd%0d_pair", n));
      else
        do_access(kind, rwe[0], ra0, rs0, rw0, $sformatf("rnd%0d_m%0d", n, kind));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
